// File: rtl/execute_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : execute_writeback_stage
// Description : Commits execute-stage ALU results to the register-file write
//               port and the status (flags) register. Byte results commit in
//               one cycle; multiplier results commit low byte to rd and high
//               byte to rd+1 over two cycles, stalling execute meanwhile.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_writeback_stage #(
  parameter int         REG_ADDR_W = 3,
  parameter logic [1:0] MUL_OPCODE = 2'b01
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [1:0]            ex_alu_operation,
  input  logic                  ex_write_enable,
  input  logic [REG_ADDR_W-1:0] ex_dest_reg,
  input  logic [15:0]           ex_result,
  input  logic [2:0]            ex_flags,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic [7:0]            rf_data,
  output logic                  flags_we,
  output logic [2:0]            flags_out,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE_LO = 2'd1,
    WRITE_HI = 2'd2
  } state_t;

  localparam logic [REG_ADDR_W-1:0] RD_STEP = {{(REG_ADDR_W-1){1'b0}}, 1'b1};

  state_t                state;
  state_t                state_next;
  logic [1:0]            hold_op;
  logic                  hold_we;
  logic [REG_ADDR_W-1:0] hold_rd;
  logic [15:0]           hold_result;
  logic [2:0]            hold_flags;
  logic                  hold_is_mul;
  logic                  transfer;

  assign hold_is_mul = (hold_op == MUL_OPCODE);
  // Only a writing multiply needs a second cycle, so only it blocks execute.
  // Ready depends on registered state alone, never on ex_valid.
  assign ex_ready    = ~((state == WRITE_LO) && hold_is_mul && hold_we);
  assign transfer    = ex_valid && ex_ready;

  // State register; reset abandons any half-committed result.
  always_ff @(posedge clock) begin
    if (nreset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the offered result whenever the handshake completes.
  always_ff @(posedge clock) begin
    if (nreset) begin
      hold_op     <= 2'b00;
      hold_we     <= 1'b0;
      hold_rd     <= '0;
      hold_result <= 16'h0000;
      hold_flags  <= 3'b000;
    end else if (transfer) begin
      hold_op     <= ex_alu_operation;
      hold_we     <= ex_write_enable;
      hold_rd     <= ex_dest_reg;
      hold_result <= ex_result;
      hold_flags  <= ex_flags;
    end
  end

  // Status register commits at the end of every low-byte cycle.
  always_ff @(posedge clock) begin
    if (nreset) begin
      flags_out <= 3'b000;
    end else if (state == WRITE_LO) begin
      flags_out <= hold_flags;
    end
  end

  // Next-state selection and output decode from registered state.
  always_comb begin
    state_next = state;
    rf_we      = 1'b0;
    rf_addr    = '0;
    rf_data    = 8'h00;
    flags_we   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (transfer) state_next = WRITE_LO;
      end
      WRITE_LO: begin
        busy     = 1'b1;
        rf_we    = hold_we;
        rf_addr  = hold_rd;
        rf_data  = hold_result[7:0];
        flags_we = 1'b1;
        if (hold_is_mul && hold_we) begin
          state_next = WRITE_HI;
        end else if (transfer) begin
          state_next = WRITE_LO;
        end else begin
          state_next = IDLE;
        end
      end
      WRITE_HI: begin
        busy       = 1'b1;
        rf_we      = 1'b1;
        rf_addr    = hold_rd + RD_STEP;
        rf_data    = hold_result[15:8];
        state_next = transfer ? WRITE_LO : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/execute_writeback_stage.md
Name: execute_writeback_stage

Overview:
Writeback stage directly downstream of the execute-stage ALU. Captures the ALU's 16-bit result and 3-bit flags plus destination info and commits them to the register file write port and the processor status (flags) register. 8-bit operations commit in one cycle. Multiplier results (16-bit) commit over two cycles: low byte to rd, high byte to rd+1. Exerts back-pressure on execute through a valid/ready handshake.

Parameters:
REG_ADDR_W, 3, register-file address width (2**REG_ADDR_W byte registers)
MUL_OPCODE, 2'b01, alu_operation encoding that selects the multiplier (16-bit result)

Ports:
clock  input  1  system clock, all state on rising edge
nreset  input  1  synchronous, active-high reset
ex_valid  input  1  execute presents a completed ALU result
ex_ready  output  1  stage can accept a result this cycle
ex_alu_operation  input  2  ALU unit select of the result (00 add, 01 mul, 10 shift, 11 logic)
ex_write_enable  input  1  result is to be written to the register file
ex_dest_reg  input  REG_ADDR_W  destination register rd
ex_result  input  16  ALU output; only [7:0] meaningful unless multiply
ex_flags  input  3  ALU flags for this result
rf_we  output  1  register-file write strobe
rf_addr  output  REG_ADDR_W  register-file write address
rf_data  output  8  register-file write data
flags_we  output  1  status register update strobe this cycle
flags_out  output  3  committed status register value
busy  output  1  stage holds an uncommitted result

Behaviour:
- Reset: nreset is synchronous, active-high; clock is clock. When nreset=1 at a rising edge: state<=IDLE, all holding registers and flags_out <= 0. Outputs during/after reset: rf_we=0, rf_addr=0, rf_data=0, flags_we=0, flags_out=3'b000, busy=0, ex_ready=1.
- Reset mid-operation (WRITE_LO or WRITE_HI) discards the pending result. No further rf_we for it.
- Handshake: transfer occurs on a rising edge with ex_valid=1 and ex_ready=1. Inputs are captured into holding registers (op, we, rd, result, flags). Execute must hold inputs stable while ex_valid=1 and ex_ready=0.
- ex_ready = ~(state==WRITE_LO && hold_is_mul && hold_we), combinational from state/holding regs only. No combinational path from ex_valid.
- hold_is_mul = (hold_op == MUL_OPCODE).
- FSM:
  IDLE: busy=0, all strobes 0. Transfer -> WRITE_LO.
  WRITE_LO: rf_we=hold_we, rf_addr=hold_rd, rf_data=hold_result[7:0], flags_we=1. At the edge, flags_out<=hold_flags. Next state:
    - if hold_is_mul and hold_we: WRITE_HI
    - else if transfer this edge: WRITE_LO with new capture
    - else: IDLE
  WRITE_HI: rf_we=1, rf_addr=hold_rd+1 (modulo 2**REG_ADDR_W, e.g. rd=7 -> 0 at width 3), rf_data=hold_result[15:8], flags_we=0. Next state: transfer -> WRITE_LO with new capture, else IDLE.
- busy=1 in WRITE_LO and WRITE_HI.
- Outputs are decoded from registered state only, with no combinational input-to-output path.
- Latency: a result accepted at edge N writes its low byte during cycle N+1 (committed at edge N+1). A multiply's high byte writes in cycle N+2.
- Throughput: 1 result/cycle for add/shift/logic. Multiply with write enable occupies 2 cycles.
- ex_write_enable=0: flags still committed (compare-style ops). No rf_we. A multiply with we=0 takes a single cycle.
- rf_addr/rf_data in IDLE hold 0. Writes occur only when rf_we=1.
- flags_out changes only at the end of a WRITE_LO cycle, or on reset.

Test Plan:
- Reset: drive nreset=1 for 2 cycles mid-stream -> rf_we=0, flags_out=000, ex_ready=1, busy=0. Deassert: no stale write.
- Add: ex_valid=1, op=00, we=1, rd=3, result=16'h00A5, flags=3'b010 -> next cycle rf_we=1, rf_addr=3, rf_data=A5, flags_we=1. flags_out=010 the cycle after.
- Multiply: op=01, rd=5, result=16'h1234 -> cycle1 addr5/data 34, ex_ready=0; cycle2 addr6/data 12. Repeat with rd=7 -> high byte to addr 0.
- Back-to-back: three add results on consecutive cycles with ex_valid held 1 -> three consecutive rf_we pulses in order, ex_ready never low.
- Mul then add with ex_valid held: add is stalled one cycle (ex_ready=0 in WRITE_LO). Add's low byte writes in the cycle after the mul high byte, with no gap beyond one.
- we=0: op=11, rd=2, flags=3'b101 -> no rf_we, flags_out=101. Assert nreset during a multiply's WRITE_LO -> no WRITE_HI write occurs.
